micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter CW, default 18: control-word width.
REQ-002 SHALL have parameter HALT_OP, default 6'h3F: opcode that stops sequencing.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port opcode  input  6  instruction-register bits [31:26], sampled at dispatch.
REQ-006 SHALL have port control  output  CW  microinstruction for the current state.
- [17:16] ALUop; [15] ALUsrcA; [14:13] ALUsrcB; [12] RegDst; [11] MemToReg; [10] RegWrite.
- [9] IorD; [8] MemRead; [7] MemWrite; [6] IRWrite; [5:4] PCSource; [3] PCWriteCond; [2] PCWrite.
- [1:0] sequencing field: 00 fetch, 01 dispatch1, 10 dispatch2, 11 next.
REQ-007 SHALL have port mpc  output  4  current micro-PC, driven directly from the state register.
REQ-008 SHALL have port illegal  output  1  one-cycle pulse when dispatch1 sees an unsupported opcode.
REQ-009 SHALL have port finish  output  1  sticky halt flag.
REQ-010 SHALL have port inst_cnt  output  16  count of completed fetch states.

Function
REQ-011 SHALL drive control as a combinational ROM lookup of the registered mpc, so control is valid in the same cycle as mpc.
REQ-012 SHALL use these ROM words (hex):
- mpc 0 = 02147 fetch; 1 = 06001 decode; 2 = 0C002 memaddr; 3 = 00303 memread; 4 = 00C00 lw writeback.
- mpc 5 = 00280 memwrite; 6 = 28003 R-exec; 7 = 01400 R-complete; 8 = 18018 branch; 9 = 00024 jump.
- mpc 10 = 00000 halt; mpc 11-15 = 00000.
REQ-013 SHALL select the next mpc from control[1:0]:
- 00 -> 0.
- 11 -> mpc+1.
- 01 -> dispatch1 table.
- 10 -> dispatch2 table.
REQ-014 Dispatch1 SHALL map opcode 0->6, 35->2, 43->2, 4->8, 2->9, HALT_OP->10, and any other opcode->0.
REQ-015 Dispatch2 SHALL map opcode 35->3 and 43->5; any other opcode SHALL go to 0.
REQ-016 In mpc 10, mpc SHALL hold and finish SHALL stay 1 until reset; opcode changes SHALL be ignored.
REQ-017 Unused mpc 11-15 SHALL return to 0 on the next edge, with no output side effects.
REQ-018 illegal SHALL be high for exactly the cycle after a dispatch1 that fell to the default entry.
REQ-019 inst_cnt SHALL increment by 1 on each edge that leaves mpc 0, wrap from FFFF to 0000, and stop counting while finish=1.
REQ-020 SHALL keep total latency at one clock per micro-state: lw = 5 cycles, sw = 4, R-type = 4, beq = 3, j = 3.

Reset
REQ-021 Asserting rst SHALL immediately force mpc=0, control=02147, illegal=0, finish=0 and inst_cnt=0.
REQ-022 Reset asserted mid-instruction or in halt SHALL abort the sequence; the first edge after release SHALL leave fetch normally.

Structure
REQ-023 A shared package SHALL hold:
- the mpc state constants S_FETCH..S_HALT;
- the sequencing-field encodings;
- the control-bit index constants of REQ-006;
- the opcode constants OP_RTYPE=0, OP_LW=35, OP_SW=43, OP_BEQ=4, OP_J=2.
REQ-024 The ROM SHALL be one sub-module, micro_rom (input mpc, output control); dispatch tables and counters SHALL remain in micro_sequencer.

Verification
REQ-025 Reset, then opcode=0 -> mpc sequence 0,1,6,7,0; control 02147,06001,28003,01400; inst_cnt=1 after the first edge.
REQ-026 opcode=35 -> mpc 0,1,2,3,4,0; opcode=43 -> mpc 0,1,2,5,0.
REQ-027 opcode=4 -> mpc 0,1,8,0 with control[3]=1 and control[5:4]=01 in mpc 8; opcode=2 -> 0,1,9,0 with control=00024.
REQ-028 opcode=6'h0F -> mpc 0,1,0; illegal=1 for one cycle only.
REQ-029 opcode=6'h3F -> mpc reaches 10 and holds; finish=1 and inst_cnt frozen while opcode toggles; rst pulse -> mpc=0, finish=0.
REQ-030 Assert rst asynchronously while mpc=3 -> mpc=0 and inst_cnt=0 before the next clock edge; preload inst_cnt to FFFF, then one fetch -> 0000.

Source files
------------

// File: rtl/micro_sequencer_pkg.sv
// Shared constants for the micro-programmed multicycle control unit:
// micro-PC states, sequencing-field encodings, control-word bit positions, opcodes.
package micro_sequencer_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADDR  = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_LWWB     = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_REXEC    = 4'd6;
    localparam logic [3:0] S_RCOMP    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_HALT     = 4'd10;

    typedef enum logic [1:0] {
        SEQ_FETCH = 2'b00,
        SEQ_DISP1 = 2'b01,
        SEQ_DISP2 = 2'b10,
        SEQ_NEXT  = 2'b11
    } seq_e;

    localparam int ALUOP_HI    = 17;
    localparam int ALUOP_LO    = 16;
    localparam int ALUSRCA     = 15;
    localparam int ALUSRCB_HI  = 14;
    localparam int ALUSRCB_LO  = 13;
    localparam int REGDST      = 12;
    localparam int MEMTOREG    = 11;
    localparam int REGWRITE    = 10;
    localparam int IORD        = 9;
    localparam int MEMREAD     = 8;
    localparam int MEMWRITE    = 7;
    localparam int IRWRITE     = 6;
    localparam int PCSRC_HI    = 5;
    localparam int PCSRC_LO    = 4;
    localparam int PCWRITECOND = 3;
    localparam int PCWRITE     = 2;
    localparam int SEQ_HI      = 1;
    localparam int SEQ_LO      = 0;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;

endpackage

// File: rtl/micro_sequencer_rom.sv
// Microcode store: combinational lookup from micro-PC to control word.
module micro_rom
    import micro_sequencer_pkg::*;
#(
    parameter int CW = 18
) (
    input  logic [3:0]    mpc,
    output logic [CW-1:0] control
);

    logic [17:0] word;

    always_comb begin
        word = 18'h00000;
        case (mpc)
            S_FETCH:    word = 18'h02147;
            S_DECODE:   word = 18'h06001;
            S_MEMADDR:  word = 18'h0C002;
            S_MEMREAD:  word = 18'h00303;
            S_LWWB:     word = 18'h00C00;
            S_MEMWRITE: word = 18'h00280;
            S_REXEC:    word = 18'h28003;
            S_RCOMP:    word = 18'h01400;
            S_BRANCH:   word = 18'h18018;
            S_JUMP:     word = 18'h00024;
            default:    word = 18'h00000;
        endcase
    end

    assign control = CW'(word);

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: ROM-driven next-state selection, dispatch tables,
// halt latch, illegal-opcode pulse and completed-fetch counter.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int         CW      = 18,
    parameter logic [5:0] HALT_OP = 6'h3F
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    opcode,
    output logic [CW-1:0] control,
    output logic [3:0]    mpc,
    output logic          illegal,
    output logic          finish,
    output logic [15:0]   inst_cnt
);

    logic [3:0]  mpc_q, mpc_d;
    logic        illegal_q, illegal_d;
    logic        finish_q, finish_d;
    logic [15:0] inst_cnt_q, inst_cnt_d;
    logic [3:0]  disp1_mpc, disp2_mpc;
    logic        disp1_miss;
    seq_e        seq;

    micro_rom #(.CW(CW)) u_rom (
        .mpc     (mpc_q),
        .control (control)
    );

    assign seq = seq_e'(control[SEQ_HI:SEQ_LO]);
    logic unused_ctrl;
    assign unused_ctrl = ^control[CW-1:SEQ_HI+1];

    always_comb begin
        disp1_mpc  = S_FETCH;
        disp1_miss = 1'b0;
        if (opcode == HALT_OP) begin
            disp1_mpc = S_HALT;
        end else begin
            case (opcode)
                OP_RTYPE:     disp1_mpc = S_REXEC;
                OP_LW, OP_SW: disp1_mpc = S_MEMADDR;
                OP_BEQ:       disp1_mpc = S_BRANCH;
                OP_J:         disp1_mpc = S_JUMP;
                default:      disp1_miss = 1'b1;
            endcase
        end
    end

    always_comb begin
        disp2_mpc = S_FETCH;
        case (opcode)
            OP_LW:   disp2_mpc = S_MEMREAD;
            OP_SW:   disp2_mpc = S_MEMWRITE;
            default: disp2_mpc = S_FETCH;
        endcase
    end

    // Halt word carries a fetch sequencing field, so halt must be trapped explicitly.
    always_comb begin
        mpc_d     = S_FETCH;
        illegal_d = 1'b0;
        if (mpc_q == S_HALT) begin
            mpc_d = S_HALT;
        end else begin
            case (seq)
                SEQ_FETCH: mpc_d = S_FETCH;
                SEQ_NEXT:  mpc_d = 4'(mpc_q + 4'd1);
                SEQ_DISP1: begin
                    mpc_d     = disp1_mpc;
                    illegal_d = disp1_miss;
                end
                SEQ_DISP2: mpc_d = disp2_mpc;
                default:   mpc_d = S_FETCH;
            endcase
        end
        finish_d   = finish_q | (mpc_d == S_HALT);
        inst_cnt_d = (mpc_q == S_FETCH && !finish_q) ? 16'(inst_cnt_q + 16'd1) : inst_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mpc_q      <= S_FETCH;
            illegal_q  <= 1'b0;
            finish_q   <= 1'b0;
            inst_cnt_q <= 16'd0;
        end else begin
            mpc_q      <= mpc_d;
            illegal_q  <= illegal_d;
            finish_q   <= finish_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    assign mpc      = mpc_q;
    assign illegal  = illegal_q;
    assign finish   = finish_q;
    assign inst_cnt = inst_cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: directed instruction sequences with
// hand-written micro-PC traces; a negedge monitor compares every pushed cycle.
module tb_micro_sequencer;
    import micro_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [17:0] control;
    logic [3:0]  mpc;
    logic        illegal;
    logic        finish;
    logic [15:0] inst_cnt;

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .control  (control),
        .mpc      (mpc),
        .illegal  (illegal),
        .finish   (finish),
        .inst_cnt (inst_cnt)
    );

    logic [39:0] exp_q[$];
    string       lbl_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_cnt;
    logic        m_fin;

    function automatic logic [17:0] rom_ref(input logic [3:0] m);
        case (m)
            4'd0:    rom_ref = 18'h02147;
            4'd1:    rom_ref = 18'h06001;
            4'd2:    rom_ref = 18'h0C002;
            4'd3:    rom_ref = 18'h00303;
            4'd4:    rom_ref = 18'h00C00;
            4'd5:    rom_ref = 18'h00280;
            4'd6:    rom_ref = 18'h28003;
            4'd7:    rom_ref = 18'h01400;
            4'd8:    rom_ref = 18'h18018;
            4'd9:    rom_ref = 18'h00024;
            default: rom_ref = 18'h00000;
        endcase
    endfunction

    task automatic push(input string l, input logic [3:0] m, input logic ill);
        if (m == 4'd10) m_fin = 1'b1;
        exp_q.push_back({m, rom_ref(m), ill, m_fin, m_cnt});
        lbl_q.push_back(l);
    endtask

    // Expect the current cycle's outputs, then advance one clock.
    task automatic cyc(input string l, input logic [3:0] m, input logic ill);
        push(l, m, ill);
        @(posedge clk);
        #1;
        if (m == 4'd0 && !m_fin) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_cnt = 16'd0;
        m_fin = 1'b0;
        push("reset", 4'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [39:0] e;
            logic [39:0] a;
            string       l;
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            a = {mpc, control, illegal, finish, inst_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got mpc=%0d ctl=%h ill=%b fin=%b cnt=%h, want mpc=%0d ctl=%h ill=%b fin=%b cnt=%h",
                         l, a[39:36], a[35:18], a[17], a[16], a[15:0],
                         e[39:36], e[35:18], e[17], e[16], e[15:0]);
            end
        end
    end

    initial begin
        logic [5:0] toggles [4];
        toggles = '{6'd0, 6'd35, 6'd4, 6'h15};
        rst    = 1'b1;
        opcode = 6'd0;
        m_cnt  = 16'd0;
        m_fin  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        opcode = 6'd0;
        cyc("r_fetch", 4'd0, 1'b0);
        cyc("r_decode", 4'd1, 1'b0);
        cyc("r_exec", 4'd6, 1'b0);
        cyc("r_comp", 4'd7, 1'b0);

        opcode = 6'd35;
        cyc("lw_fetch", 4'd0, 1'b0);
        cyc("lw_decode", 4'd1, 1'b0);
        cyc("lw_addr", 4'd2, 1'b0);
        cyc("lw_read", 4'd3, 1'b0);
        cyc("lw_wb", 4'd4, 1'b0);

        opcode = 6'd43;
        cyc("sw_fetch", 4'd0, 1'b0);
        cyc("sw_decode", 4'd1, 1'b0);
        cyc("sw_addr", 4'd2, 1'b0);
        cyc("sw_write", 4'd5, 1'b0);

        opcode = 6'd4;
        cyc("beq_fetch", 4'd0, 1'b0);
        cyc("beq_decode", 4'd1, 1'b0);
        cyc("beq_branch", 4'd8, 1'b0);

        opcode = 6'd2;
        cyc("j_fetch", 4'd0, 1'b0);
        cyc("j_decode", 4'd1, 1'b0);
        cyc("j_jump", 4'd9, 1'b0);

        opcode = 6'h0F;
        cyc("ill_fetch", 4'd0, 1'b0);
        cyc("ill_decode", 4'd1, 1'b0);
        opcode = 6'd2;
        cyc("ill_pulse", 4'd0, 1'b1);
        cyc("ill_clear", 4'd1, 1'b0);
        cyc("ill_next_j", 4'd9, 1'b0);

        // Abort a load while it sits in the memory-read state.
        opcode = 6'd35;
        cyc("ab_fetch", 4'd0, 1'b0);
        cyc("ab_decode", 4'd1, 1'b0);
        cyc("ab_addr", 4'd2, 1'b0);
        do_reset();

        force dut.inst_cnt_q = 16'hFFFF;
        #1;
        release dut.inst_cnt_q;
        m_cnt  = 16'hFFFF;
        opcode = 6'd2;
        cyc("wrap_fetch", 4'd0, 1'b0);
        cyc("wrap_decode", 4'd1, 1'b0);
        cyc("wrap_jump", 4'd9, 1'b0);
        cyc("wrap_fetch2", 4'd0, 1'b0);
        cyc("wrap_decode2", 4'd1, 1'b0);
        cyc("wrap_jump2", 4'd9, 1'b0);

        opcode = 6'h3F;
        cyc("halt_fetch", 4'd0, 1'b0);
        cyc("halt_decode", 4'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc("halt_hold", 4'd10, 1'b0);
            opcode = toggles[i];
        end
        cyc("halt_hold_last", 4'd10, 1'b0);
        do_reset();

        opcode = 6'd0;
        cyc("post_fetch", 4'd0, 1'b0);
        cyc("post_decode", 4'd1, 1'b0);
        cyc("post_exec", 4'd6, 1'b0);
        cyc("post_comp", 4'd7, 1'b0);
        cyc("post_fetch2", 4'd0, 1'b0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
